// File: rtl/v850_mem_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
package v850_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 25;
    localparam int unsigned MEM_DATA_W = 64;
    localparam int unsigned MEM_BE_W   = MEM_DATA_W / 8;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STALL
    } arb_state_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } resp_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-macro signals around the port arbiter.
// slave: the arbiter's view; master: the surrounding pipeline and memory.
interface mem_port_arbiter_if
    import v850_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic                ls_req;
    logic                ls_we;
    logic [ADDR_W-1:0]   ls_addr;
    logic [DATA_W-1:0]   ls_wdata;
    logic [MEM_BE_W-1:0] ls_be;
    logic                ls_gnt;
    logic                ls_rvalid;
    logic [DATA_W-1:0]   ls_rdata;

    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [MEM_BE_W-1:0] mem_be;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_resp_tag_pipe.sv
// Shift register of response tags, one stage per cycle of memory read latency.
// An IF flush invalidates every IF-owned tag, including the one entering this cycle.
module mem_resp_tag_pipe
    import v850_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  resp_tag_t push_i,
    input  logic      flush_if_i,
    output resp_tag_t tag_o
);

    resp_tag_t pipe_q [DEPTH];
    resp_tag_t pipe_d [DEPTH];

    // Shift one stage, then drop IF ownership validity on flush.
    always_comb begin
        pipe_d[0] = push_i;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (flush_if_i && pipe_d[i].owner == OWN_IF) begin
                pipe_d[i].valid = 1'b0;
            end
        end
    end

    // Tag storage with synchronous clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst_n) begin
                pipe_q[i] <= '0;
            end else begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared 64-bit memory port between instruction fetch and load/store.
// Load/store has priority. Optional starvation guard enabled by defining STARVE_GUARD_EN.
module mem_port_arbiter
    import v850_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = MEM_ADDR_W,
    parameter int unsigned DATA_W     = MEM_DATA_W,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    if (RD_LATENCY < 1 || RD_LATENCY > 4 || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_port_arbiter: RD_LATENCY must be 1..4 and STARVE_MAX >= 1");
    end

    arb_state_t          state_q, state_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MEM_BE_W-1:0] mem_be_q, mem_be_d;
    owner_t              mem_owner_q, mem_owner_d;

    logic      hold;
    logic      accepted;
    logic      if_gnt;
    logic      ls_gnt;
    logic      if_force;
    resp_tag_t push_tag;
    resp_tag_t tail_tag;

    // A strobe on the port that memory has not taken blocks new grants.
    assign hold     = (state_q != IDLE) && !bus.mem_ready;
    assign accepted = (state_q != IDLE) && bus.mem_ready;

`ifdef STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign if_force = bus.if_req && (starve_q == CNT_W'(STARVE_MAX));

    // Count consecutive cycles the waiting fetch lost to load/store.
    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req || if_gnt) begin
            starve_d = '0;
        end else if (ls_gnt) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign if_force = 1'b0;
`endif

    // Grant selection: LS first unless the fetch has been starved too long.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!hold) begin
            if (bus.if_req && (if_force || !bus.ls_req)) begin
                if_gnt = 1'b1;
            end else if (bus.ls_req) begin
                ls_gnt = 1'b1;
            end
        end
    end

    // Next port state: hold on stall, load the granted request, else go quiet.
    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        mem_owner_d = mem_owner_q;
        if (hold) begin
            state_d = STALL;
        end else if (ls_gnt) begin
            state_d     = ISSUE;
            mem_en_d    = 1'b1;
            mem_we_d    = bus.ls_we;
            mem_addr_d  = bus.ls_addr;
            mem_wdata_d = bus.ls_we ? bus.ls_wdata : '0;
            mem_be_d    = bus.ls_we ? bus.ls_be : '0;
            mem_owner_d = OWN_LS;
        end else if (if_gnt) begin
            state_d     = ISSUE;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            mem_be_d    = '0;
            mem_owner_d = OWN_IF;
        end else begin
            state_d  = IDLE;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
        end
    end

    // Port FSM and registered memory outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            mem_owner_q <= OWN_IF;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            mem_owner_q <= mem_owner_d;
        end
    end

    // Writes travel down the pipe as bubbles so response order stays aligned.
    assign push_tag.valid = accepted && !mem_we_q;
    assign push_tag.owner = mem_owner_q;

    mem_resp_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push_tag),
        .flush_if_i (bus.if_flush),
        .tag_o      (tail_tag)
    );

    assign bus.if_gnt    = if_gnt;
    assign bus.ls_gnt    = ls_gnt;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;

    // A fetch response arriving in a flush cycle is already stale.
    assign bus.if_rvalid = tail_tag.valid && tail_tag.owner == OWN_IF && !bus.if_flush;
    assign bus.ls_rvalid = tail_tag.valid && tail_tag.owner == OWN_LS;
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    assign bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : '0;

endmodule
